// File: rtl/shwr_pulse_gen_if.sv
// Parameter/result bundle for the synthetic shower pulse generator.
// The master side requests pulses; the slave side produces samples and expectations.
interface shwr_pulse_gen_if #(
    parameter int ADC_WIDTH  = 12,
    parameter int AREA_WIDTH = 19
);
    logic                  START;
    logic [ADC_WIDTH-1:0]  BASE;
    logic [ADC_WIDTH-1:0]  AMPL;
    logic [ADC_WIDTH-1:0]  STEP;
    logic [7:0]            PRE_LEN;
    logic [7:0]            FLAT_LEN;
    logic [3:0]            DECAY_SHIFT;
    logic [11:0]           TRIG_LEN;

    logic [ADC_WIDTH-1:0]  ADC;
    logic                  TRIGGERED;
    logic                  BUSY;
    logic                  DONE;
    logic [AREA_WIDTH-1:0] EXP_AREA;
    logic [ADC_WIDTH-1:0]  EXP_PEAK;
    logic                  EXP_SAT;

    modport master (
        output START, BASE, AMPL, STEP, PRE_LEN, FLAT_LEN, DECAY_SHIFT, TRIG_LEN,
        input  ADC, TRIGGERED, BUSY, DONE, EXP_AREA, EXP_PEAK, EXP_SAT
    );

    modport slave (
        input  START, BASE, AMPL, STEP, PRE_LEN, FLAT_LEN, DECAY_SHIFT, TRIG_LEN,
        output ADC, TRIGGERED, BUSY, DONE, EXP_AREA, EXP_PEAK, EXP_SAT
    );
endinterface

// File: rtl/shwr_pulse_gen.sv
// Synthetic shower pulse generator: baseline, rise, flat top, exponential-ish
// decay, plus a trigger window and the expected area/peak/saturation of it.
module shwr_pulse_gen #(
    parameter int ADC_WIDTH  = 12,
    parameter int AREA_WIDTH = 19,
    parameter int SAT_LEVEL  = 4095
) (
    input logic             CLK120,
    input logic             RESET,
    shwr_pulse_gen_if.slave bus
);

    localparam int W  = ADC_WIDTH;
    localparam int AW = AREA_WIDTH;
    localparam logic [W-1:0] ADC_MAX = '1;
    localparam logic [W-1:0] SAT_LVL = W'(SAT_LEVEL);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        RISE,
        FLAT,
        DECAY,
        TAIL,
        FIN
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [W-1:0]   lvl_q, lvl_d;
    logic           trig_q, trig_d;
    logic [11:0]    tcnt_q, tcnt_d;
    logic [W-1:0]   adc_q, adc_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [AW-1:0]  area_q, area_d;
    logic [W-1:0]   peak_q, peak_d;
    logic           sat_q, sat_d;

    logic [W-1:0]   base_q, base_d;
    logic [W-1:0]   ampl_q, ampl_d;
    logic [W-1:0]   step_q, step_d;
    logic [7:0]     flat_q, flat_d;
    logic [3:0]     shift_q, shift_d;
    logic [11:0]    tlen_q, tlen_d;

    logic [W-1:0]   step_eff;
    logic [W:0]     rise_sum;
    logic [W-1:0]   rise_lvl;
    logic [W-1:0]   dec_shr;
    logic [W-1:0]   dec_amt;
    logic [W-1:0]   dec_lvl;
    logic [W-1:0]   lvl_new;
    logic [W:0]     pulse_sum;
    logic [W-1:0]   pulse_adc;
    logic [W-1:0]   diff;
    logic [AW:0]    diff_ext;
    logic [AW:0]    area_sum;
    logic           win_end;

    // Level arithmetic shared by the pulse states; sums carry an extra bit to clip.
    always_comb begin
        step_eff = (step_q == '0) ? ampl_q : step_q;
        rise_sum = {1'b0, lvl_q} + {1'b0, step_eff};
        if (rise_sum >= {1'b0, ampl_q}) begin
            rise_lvl = ampl_q;
        end else begin
            rise_lvl = rise_sum[W-1:0];
        end

        dec_shr = lvl_q >> shift_q;
        dec_amt = (dec_shr == '0) ? W'(1) : dec_shr;
        dec_lvl = (lvl_q > dec_amt) ? (lvl_q - dec_amt) : '0;

        lvl_new = lvl_q;
        if (state_q == RISE) begin
            lvl_new = rise_lvl;
        end else if (state_q == DECAY) begin
            lvl_new = dec_lvl;
        end

        pulse_sum = {1'b0, base_q} + {1'b0, lvl_new};
        pulse_adc = pulse_sum[W] ? ADC_MAX : pulse_sum[W-1:0];

        diff = adc_q - base_q;
        diff_ext = '0;
        diff_ext[W-1:0] = diff;
        area_sum = {1'b0, area_q} + diff_ext;

        win_end = !trig_q || (tcnt_q == '0);
    end

    // Next-state, sample, trigger window and expectation bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        trig_d  = trig_q;
        tcnt_d  = tcnt_q;
        adc_d   = adc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        area_d  = area_q;
        peak_d  = peak_q;
        sat_d   = sat_q;
        base_d  = base_q;
        ampl_d  = ampl_q;
        step_d  = step_q;
        flat_d  = flat_q;
        shift_d = shift_q;
        tlen_d  = tlen_q;

        // The window counts down on its own once opened by the first rise.
        if (trig_q) begin
            if (tcnt_q == '0) begin
                trig_d = 1'b0;
            end else begin
                tcnt_d = tcnt_q - 12'd1;
            end
            area_d = area_sum[AW] ? '1 : area_sum[AW-1:0];
            if (diff > peak_q) begin
                peak_d = diff;
            end
            if (adc_q >= SAT_LVL) begin
                sat_d = 1'b1;
            end
        end

        if ((state_q == RISE) && (lvl_q == '0) && (tlen_q != '0)) begin
            trig_d = 1'b1;
            tcnt_d = tlen_q - 12'd1;
        end

        case (state_q)
            IDLE: begin
                adc_d  = bus.BASE;
                busy_d = 1'b0;
                if (bus.START) begin
                    base_d  = bus.BASE;
                    ampl_d  = bus.AMPL;
                    step_d  = bus.STEP;
                    flat_d  = bus.FLAT_LEN;
                    shift_d = bus.DECAY_SHIFT;
                    tlen_d  = bus.TRIG_LEN;
                    area_d  = '0;
                    peak_d  = '0;
                    sat_d   = 1'b0;
                    lvl_d   = '0;
                    trig_d  = 1'b0;
                    tcnt_d  = '0;
                    busy_d  = 1'b1;
                    cnt_d   = bus.PRE_LEN;
                    state_d = (bus.PRE_LEN != '0) ? PRE : RISE;
                end
            end
            PRE: begin
                adc_d = base_q;
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = RISE;
                end
            end
            RISE: begin
                lvl_d = rise_lvl;
                adc_d = pulse_adc;
                if (rise_lvl == ampl_q) begin
                    if (flat_q != '0) begin
                        cnt_d   = flat_q;
                        state_d = FLAT;
                    end else begin
                        state_d = DECAY;
                    end
                end
            end
            FLAT: begin
                adc_d = pulse_adc;
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = DECAY;
                end
            end
            DECAY: begin
                lvl_d = dec_lvl;
                adc_d = pulse_adc;
                if (dec_lvl == '0) begin
                    state_d = TAIL;
                end
            end
            TAIL: begin
                adc_d = base_q;
                if (win_end) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                adc_d   = base_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any sequence without DONE.
    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lvl_q   <= '0;
            trig_q  <= 1'b0;
            tcnt_q  <= '0;
            adc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            area_q  <= '0;
            peak_q  <= '0;
            sat_q   <= 1'b0;
            base_q  <= '0;
            ampl_q  <= '0;
            step_q  <= '0;
            flat_q  <= '0;
            shift_q <= '0;
            tlen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            trig_q  <= trig_d;
            tcnt_q  <= tcnt_d;
            adc_q   <= adc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            area_q  <= area_d;
            peak_q  <= peak_d;
            sat_q   <= sat_d;
            base_q  <= base_d;
            ampl_q  <= ampl_d;
            step_q  <= step_d;
            flat_q  <= flat_d;
            shift_q <= shift_d;
            tlen_q  <= tlen_d;
        end
    end

    assign bus.ADC       = adc_q;
    assign bus.TRIGGERED = trig_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.EXP_AREA  = area_q;
    assign bus.EXP_PEAK  = peak_q;
    assign bus.EXP_SAT   = sat_q;

endmodule
